// File: rtl/uart_rx_matrix_loader.sv
// uart_rx_matrix_loader
//   Receives 8N1 UART bytes (LSB first, 8x oversampled) and stores them
//   sequentially into a ROW*COLUMN byte matrix while write_A_TX is high.
//   Ten independent read ports return stored bytes with one clk of latency.
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous active-low reset
//   rx_data             asynchronous serial line, idle high
//   write_A_TX          load enable (frame acceptance and memory writes)
//   read_A              read strobe shared by all read ports
//   read_address_A0..9  read addresses; out-of-range addresses return 8'h00
//   data_A0..9          registered read data, held while read_A is low
//   written_completed   high once all ROW*COLUMN bytes have been stored
module uart_rx_matrix_loader #(
  parameter int ROW     = 2,
  parameter int COLUMN  = 2,
  parameter int OVS_DIV = 1302
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_data,
  input  logic        write_A_TX,
  input  logic        read_A,
  input  logic [31:0] read_address_A0,
  input  logic [31:0] read_address_A1,
  input  logic [31:0] read_address_A2,
  input  logic [31:0] read_address_A3,
  input  logic [31:0] read_address_A4,
  input  logic [31:0] read_address_A5,
  input  logic [31:0] read_address_A6,
  input  logic [31:0] read_address_A7,
  input  logic [31:0] read_address_A8,
  input  logic [31:0] read_address_A9,
  output logic [7:0]  data_A0,
  output logic [7:0]  data_A1,
  output logic [7:0]  data_A2,
  output logic [7:0]  data_A3,
  output logic [7:0]  data_A4,
  output logic [7:0]  data_A5,
  output logic [7:0]  data_A6,
  output logic [7:0]  data_A7,
  output logic [7:0]  data_A8,
  output logic [7:0]  data_A9,
  output logic        written_completed
);

  localparam int          TOTAL    = ROW * COLUMN;
  localparam logic [31:0] OVS_LAST = 32'(OVS_DIV - 1);
  localparam logic [3:0]  LAST_IDX = 4'(TOTAL - 1);

  // Oversample tick generator
  logic [31:0] ovs_cnt;
  logic        tick;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovs_cnt <= '0;
      tick    <= 1'b0;
    end else if (ovs_cnt == OVS_LAST) begin
      ovs_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      ovs_cnt <= ovs_cnt + 32'd1;
      tick    <= 1'b0;
    end
  end

  // Two-flop synchronizer, reset to the idle (high) line level
  logic rx_meta, rx_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_sync <= rx_meta;
    end
  end

  // Serial receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t  rx_state;
  logic [2:0] rx_ticks;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       rx_status;
  logic       frame_valid;
  logic       frame_start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_ticks    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_status   <= 1'b0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        unique case (rx_state)
          RX_IDLE: begin
            if (!rx_sync) begin
              rx_state    <= RX_START;
              rx_status   <= 1'b1;
              frame_valid <= 1'b0;
              frame_start <= 1'b1;
              rx_ticks    <= '0;
            end
          end
          RX_START: begin
            if (rx_ticks == 3'd3) begin
              rx_ticks <= '0;
              bit_idx  <= '0;
              if (rx_sync) begin
                rx_state  <= RX_IDLE;
                rx_status <= 1'b0;
              end else begin
                rx_state <= RX_DATA;
              end
            end else begin
              rx_ticks <= rx_ticks + 3'd1;
            end
          end
          RX_DATA: begin
            if (rx_ticks == 3'd7) begin
              rx_ticks <= '0;
              shift    <= {rx_sync, shift[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) rx_state <= RX_STOP;
            end else begin
              rx_ticks <= rx_ticks + 3'd1;
            end
          end
          RX_STOP: begin
            if (rx_ticks == 3'd7) begin
              rx_ticks    <= '0;
              rx_status   <= 1'b0;
              frame_valid <= rx_sync;
              rx_state    <= RX_IDLE;
            end else begin
              rx_ticks <= rx_ticks + 3'd1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // Load controller, memory and read ports
  typedef enum logic [1:0] {IDLE, RECEIVING, STORE, END} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [7:0]  mem    [TOTAL];
  logic [31:0] rd_addr[10];
  logic [7:0]  data_q [10];

  assign rd_addr[0] = read_address_A0;
  assign rd_addr[1] = read_address_A1;
  assign rd_addr[2] = read_address_A2;
  assign rd_addr[3] = read_address_A3;
  assign rd_addr[4] = read_address_A4;
  assign rd_addr[5] = read_address_A5;
  assign rd_addr[6] = read_address_A6;
  assign rd_addr[7] = read_address_A7;
  assign rd_addr[8] = read_address_A8;
  assign rd_addr[9] = read_address_A9;

  assign data_A0 = data_q[0];
  assign data_A1 = data_q[1];
  assign data_A2 = data_q[2];
  assign data_A3 = data_q[3];
  assign data_A4 = data_q[4];
  assign data_A5 = data_q[5];
  assign data_A6 = data_q[6];
  assign data_A7 = data_q[7];
  assign data_A8 = data_q[8];
  assign data_A9 = data_q[9];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < TOTAL; i++)
      if (a == i) r = mem[i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      count             <= '0;
      written_completed <= 1'b0;
      for (int unsigned i = 0; i < TOTAL; i++) mem[i] <= '0;
      for (int unsigned n = 0; n < 10; n++) data_q[n] <= '0;
    end else begin
      unique case (state)
        // Capture only from the clk the receiver announces a new start bit,
        // so a frame already underway when write_A_TX rises is skipped.
        IDLE:      if (rx_status && write_A_TX && frame_start) state <= RECEIVING;
        RECEIVING: if (!rx_status) state <= STORE;
        STORE: begin
          if (frame_valid && write_A_TX) begin
            for (int unsigned i = 0; i < TOTAL; i++)
              if (count == 4'(i)) mem[i] <= shift;
            count <= count + 4'd1;
            if (count >= LAST_IDX) begin
              state             <= END;
              written_completed <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        END:     state <= END;
        default: state <= IDLE;
      endcase
      // Reads see pre-write contents because mem updates non-blocking.
      if (read_A)
        for (int unsigned n = 0; n < 10; n++) data_q[n] <= mem_rd(rd_addr[n]);
    end
  end

endmodule

// File: tb/tb_uart_rx_matrix_loader.sv
module tb_uart_rx_matrix_loader;
  localparam int OVS = 4;
  localparam int BIT = 8 * OVS;

  logic        clk = 1'b0;
  logic        rst, rx, wr, rd;
  logic [31:0] ra[10];
  logic [7:0]  da[10];
  logic        wc;

  always #5 clk = ~clk;

  uart_rx_matrix_loader #(.ROW(2), .COLUMN(2), .OVS_DIV(OVS)) dut (
    .clk(clk), .rst(rst), .rx_data(rx), .write_A_TX(wr), .read_A(rd),
    .read_address_A0(ra[0]), .read_address_A1(ra[1]), .read_address_A2(ra[2]),
    .read_address_A3(ra[3]), .read_address_A4(ra[4]), .read_address_A5(ra[5]),
    .read_address_A6(ra[6]), .read_address_A7(ra[7]), .read_address_A8(ra[8]),
    .read_address_A9(ra[9]),
    .data_A0(da[0]), .data_A1(da[1]), .data_A2(da[2]), .data_A3(da[3]),
    .data_A4(da[4]), .data_A5(da[5]), .data_A6(da[6]), .data_A7(da[7]),
    .data_A8(da[8]), .data_A9(da[9]),
    .written_completed(wc)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mem_m[4];
  int         mcount;
  logic       mdone;
  logic [7:0] last_exp[10];
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
    for (int i = 0; i < 10; i++) last_exp[i] = 8'h00;
    mcount = 0;
    mdone  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx  = 1'b1;
    rd  = 1'b0;
    step(3);
    rst = 1'b1;
    model_clear();
    step(2);
  endtask

  // Drives one frame; the model stores it only if the byte should land.
  task automatic send(input logic [7:0] d, input logic stop_bit);
    logic accept;
    accept = wr && stop_bit && !mdone;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT);
    end
    rx = stop_bit;
    step(BIT);
    rx = 1'b1;
    step(2 * BIT);
    if (accept) begin
      mem_m[mcount] = d;
      mcount++;
      if (mcount == 4) mdone = 1'b1;
    end
  endtask

  task automatic read_all(input int base, input bit reverse);
    logic [7:0] e, o;
    for (int n = 0; n < 10; n++) begin
      ra[n] = reverse ? 32'(base + 9 - n) : 32'(base + n);
      e = (ra[n] < 4) ? mem_m[ra[n]] : 8'h00;
      sb_q.push_back(e);
      last_exp[n] = e;
    end
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    for (int n = 0; n < 10; n++) begin
      o = da[n];
      chk($sformatf("read port%0d addr%0d", n, ra[n]), 32'(o), 32'(sb_q.pop_front()));
    end
  endtask

  task automatic hold_check();
    for (int n = 0; n < 10; n++) begin
      ra[n] = $urandom_range(0, 3);
      sb_q.push_back(last_exp[n]);
    end
    step(3);
    for (int n = 0; n < 10; n++)
      chk($sformatf("hold port%0d", n), 32'(da[n]), 32'(sb_q.pop_front()));
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b0; rx = 1'b1; wr = 1'b0; rd = 1'b0;
    for (int n = 0; n < 10; n++) ra[n] = '0;

    // Reset state
    do_reset();
    chk("reset wc", 32'(wc), 32'd0);
    for (int n = 0; n < 10; n++) chk($sformatf("reset data port%0d", n), 32'(da[n]), 32'd0);

    // Reset during data bit 3 aborts the frame
    wr = 1'b1;
    d  = 8'hC3;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      step(BIT);
    end
    rx = d[3];
    step(BIT / 2);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    rx  = 1'b1;
    model_clear();
    step(3 * BIT);
    send(8'hAB, 1'b1);
    read_all(0, 1'b0);
    chk("wc after AB", 32'(wc), 32'd0);

    // Fill the matrix
    do_reset();
    wr = 1'b1;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    chk("wc after 3 stores", 32'(wc), 32'(mdone));
    send(8'h44, 1'b1);
    chk("wc after 4 stores", 32'(wc), 32'(mdone));
    read_all(0, 1'b0);
    hold_check();

    // Frames after completion are ignored
    send(8'h99, 1'b1);
    read_all(0, 1'b1);
    chk("wc still set", 32'(wc), 32'd1);
    do_reset();
    chk("wc after rst", 32'(wc), 32'd0);
    read_all(0, 1'b0);

    // Disabled load, bad stop bit, glitch, late enable
    wr = 1'b0;
    send(8'h55, 1'b1);
    read_all(0, 1'b0);
    wr = 1'b1;
    send(8'h66, 1'b1);
    send(8'h77, 1'b0);
    read_all(0, 1'b0);

    rx = 1'b0;
    step(2 * OVS);
    rx = 1'b1;
    step(4);
    chk("glitch rx_status high", 32'(dut.rx_status), 32'd1);
    step(BIT);
    chk("glitch rx_status dropped", 32'(dut.rx_status), 32'd0);

    wr = 1'b0;
    d  = 8'h5A;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 2) wr = 1'b1;
      step(BIT);
    end
    rx = 1'b1;
    step(3 * BIT);
    read_all(0, 1'b0);

    send(8'h22, 1'b1);
    read_all(0, 1'b1);
    chk("wc partial", 32'(wc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
